// File: rtl/sm_pkg.sv
// Shared constants and the compiled-in boot image for sm_rom.
// The image table stands in for sm_rom_<NODE_ID>.hex so no file access is needed at elaboration.
package sm_pkg;

  localparam int    SM_WORD_W          = 32;
  localparam int    SM_ROM_SIZE_DEF    = 64;
  localparam string SM_ROM_FILE_PREFIX = "sm_rom_";

  typedef logic [SM_WORD_W-1:0] sm_word_t;

  // Contents of sm_rom_<node_id>.hex; any word the image does not list reads as zero.
  function automatic sm_word_t sm_image_word(input int node_id, input int idx);
    sm_word_t w;
    w = '0;
    if (node_id == 0) begin
      case (idx)
        0:       w = 32'h00500093;
        1:       w = 32'h00a00113;
        2:       w = 32'h002081b3;
        3:       w = 32'h0000006f;
        default: w = '0;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/sm_rom_if.sv
// Read and load-port bundle for sm_rom; the ROM side uses the slave modport.
interface sm_rom_if
  import sm_pkg::*;
#(
  parameter int SIZE = SM_ROM_SIZE_DEF
);
  localparam int PW = $clog2(SIZE + 1);

  // Load handshake: ld_valid is a one-cycle write strobe with no ready; the master must
  // watch ld_full, because a strobe seen while ld_full is high is dropped silently.
  logic [31:0]   a;
  sm_word_t      rd;
  logic          ld_valid;
  sm_word_t      ld_data;
  logic [PW-1:0] ld_ptr;
  logic          ld_full;

  modport master (
    output a, ld_valid, ld_data,
    input  rd, ld_ptr, ld_full
  );

  modport slave (
    input  a, ld_valid, ld_data,
    output rd, ld_ptr, ld_full
  );

endinterface

// File: rtl/sm_register.sv
// Plain d->q register with asynchronous active-low clear; also serves as the CPU PC register.
module sm_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/sm_rom.sv
// Zero-latency word ROM preloaded with a boot image, with an optional sequential load port.
// Load port is built only when SM_ROM_LOAD_EN is defined; otherwise the contents are fixed.
module sm_rom
  import sm_pkg::*;
#(
  parameter int NODE_ID = 0,
  parameter int SIZE    = SM_ROM_SIZE_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  sm_rom_if.slave  bus
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PW = $clog2(SIZE + 1);

  sm_word_t      mem_w [SIZE];
  logic          in_range;
  logic [PW-1:0] ld_ptr_q;
  logic [PW-1:0] ld_ptr_d;

  // Full 32-bit compare so out-of-range addresses never alias onto low words.
  assign in_range = (bus.a < 32'(SIZE));
  assign bus.rd   = in_range ? mem_w[bus.a[AW-1:0]] : '0;

`ifdef SM_ROM_LOAD_EN

  logic ld_full;
  logic ld_we;

  assign ld_full = (ld_ptr_q == PW'(SIZE));
  // Gating with rst_n keeps a strobe held through reset from writing on the release edge.
  assign ld_we    = bus.ld_valid & ~ld_full & rst_n;
  assign ld_ptr_d = ld_we ? (ld_ptr_q + PW'(1)) : ld_ptr_q;

  sm_register #(.WIDTH(PW)) u_ld_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ld_ptr_d),
    .q     (ld_ptr_q)
  );

  // Words start from the image and are not touched by reset, only by the load port.
  for (genvar g = 0; g < SIZE; g++) begin : g_word
    sm_word_t word_q = sm_image_word(NODE_ID, g);

    always_ff @(posedge clk) begin
      if (ld_we && (ld_ptr_q == PW'(g))) word_q <= bus.ld_data;
    end

    assign mem_w[g] = word_q;
  end

  assign bus.ld_ptr  = ld_ptr_q;
  assign bus.ld_full = ld_full;

`else

  logic unused_load;

  // Pointer register kept with a zero input so both builds share the same structure.
  assign ld_ptr_d = '0;

  sm_register #(.WIDTH(PW)) u_ld_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ld_ptr_d),
    .q     (ld_ptr_q)
  );

  for (genvar g = 0; g < SIZE; g++) begin : g_word
    assign mem_w[g] = sm_image_word(NODE_ID, g);
  end

  assign bus.ld_ptr  = '0;
  assign bus.ld_full = 1'b0;
  assign unused_load = ^{bus.ld_valid, bus.ld_data, ld_ptr_q};

`endif

endmodule

// File: tb/tb_sm_rom.sv
// Randomized self-checking bench for sm_rom and sm_register against an array/pointer model.
module tb_sm_rom;
  import sm_pkg::*;

  localparam int SIZE = 64;
`ifdef SM_ROM_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_rom_if #(.SIZE(SIZE)) bus ();

  sm_rom #(.NODE_ID(0), .SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic        r_rst_n = 1'b0;
  logic [31:0] r_d     = 32'h0;
  logic [31:0] r_q;

  sm_register #(.WIDTH(32)) u_reg (
    .clk   (clk),
    .rst_n (r_rst_n),
    .d     (r_d),
    .q     (r_q)
  );

  // ---------------- reference model ----------------
  logic [31:0] exp_mem [SIZE];
  int          exp_ptr;
  logic [31:0] exp_q [$];
  logic [31:0] boot_img [4] = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h0000006f};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    if (addr < 32'(SIZE)) return exp_mem[int'(addr)];
    return 32'h0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic read_check(input string tag, input logic [31:0] addr);
    @(negedge clk);
    bus.a = addr;
    #1;
    check(tag, bus.rd, model_rd(addr));
  endtask

  task automatic check_ptr(input string tag);
    check({tag, "_ptr"},  32'(bus.ld_ptr),  32'(exp_ptr));
    check({tag, "_full"}, 32'(bus.ld_full), 32'(exp_ptr == SIZE));
  endtask

  // One clock of the load port; the model applies the write at the rising edge.
  task automatic load_cycle(input logic valid, input logic [31:0] data);
    @(negedge clk);
    bus.ld_valid = valid;
    bus.ld_data  = data;
    @(posedge clk);
    if (LOAD_EN && valid && rst_n && exp_ptr < SIZE) begin
      exp_mem[exp_ptr] = data;
      exp_ptr++;
    end
    #1;
    bus.ld_valid = 1'b0;
  endtask

  // ---------------- sm_register checks ----------------
  initial begin
    #2;
    r_d = 32'h10;
    #1;
    check("reg_in_reset", r_q, 32'h0);
    @(negedge clk);
    r_rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reg_load", r_q, 32'h10);
    #2;
    r_rst_n = 1'b0;
    #1;
    check("reg_async_clr", r_q, 32'h0);
    @(negedge clk);
    r_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r_d = $urandom;
      @(posedge clk);
      #1;
      check("reg_follow", r_q, r_d);
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [31:0] addr;
    logic [31:0] first_word;

    for (int i = 0; i < SIZE; i++) exp_mem[i] = (i < 4) ? boot_img[i] : 32'h0;
    exp_ptr      = 0;
    bus.a        = 32'h0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 32'h0;

    #3;
    check_ptr("reset");
    check("rd_in_reset", bus.rd, 32'h00500093);

    // ld_valid held across an edge while in reset must be ignored.
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    check_ptr("valid_in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    read_check("rd_word0", 32'h0);
    read_check("rd_word3", 32'h3);
    read_check("rd_at_size", 32'(SIZE));
    read_check("rd_size_p3", 32'(SIZE + 3));
    read_check("rd_huge", 32'h40000000);
    read_check("rd_all_ones", 32'hFFFFFFFF);
    read_check("rd_last", 32'(SIZE - 1));

    load_cycle(1'b1, 32'd11);
    load_cycle(1'b1, 32'd22);
    load_cycle(1'b1, 32'd33);
    check_ptr("three_loads");
    read_check("rd_a1", 32'h1);
    read_check("rd_a0", 32'h0);
    read_check("rd_a2", 32'h2);

    load_cycle(1'b0, 32'hFFFFFFFF);
    check_ptr("idle");

    // Same-address read and load: old word before the edge, new word right after it.
    @(negedge clk);
    addr         = 32'(exp_ptr);
    bus.a        = addr;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h0BADF00D;
    #1;
    check("rd_before_edge", bus.rd, model_rd(addr));
    @(posedge clk);
    if (LOAD_EN && exp_ptr < SIZE) begin
      exp_mem[exp_ptr] = 32'h0BADF00D;
      exp_ptr++;
    end
    #1;
    bus.ld_valid = 1'b0;
    check("rd_after_edge", bus.rd, model_rd(addr));

    load_cycle(1'b1, 32'h55);
    check_ptr("at_five");

    // Reset pulsed entirely between edges.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_ptr = 0;
    check_ptr("mid_reset");
    bus.a = 32'h4;
    #1;
    check("rd_kept_a4", bus.rd, model_rd(32'h4));
    rst_n = 1'b1;

    // Randomized phase with rare resets spanning an edge.
    for (int cyc = 0; cyc < 200; cyc++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        exp_ptr = 0;
        load_cycle(1'($urandom_range(0, 1)), $urandom);
        check_ptr("rand_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end
      load_cycle(1'($urandom_range(0, 9) < 7), $urandom);
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, SIZE + 7));
      read_check("rand_rd", addr);
      check_ptr("rand");
    end

    // Fill to the end, then one strobe while full.
    for (int i = 0; i < SIZE && (!LOAD_EN || exp_ptr < SIZE); i++)
      load_cycle(1'b1, LOAD_EN ? $urandom : 32'hFFFFFFFF);
    check_ptr("filled");
    first_word = exp_mem[0];
    load_cycle(1'b1, 32'hDEADBEEF);
    check_ptr("write_when_full");
    read_check("rd0_after_full", 32'h0);
    check("model_word0", model_rd(32'h0), first_word);
    for (int i = 0; i < 10; i++) load_cycle(1'b1, 32'hFFFFFFFF);
    check_ptr("strobes_when_full");

    // Scoreboard sweep of every word.
    for (int i = 0; i < SIZE; i++) exp_q.push_back(exp_mem[i]);
    for (int i = 0; i < SIZE; i++) begin
      @(negedge clk);
      bus.a = 32'(i);
      #1;
      check("sweep", bus.rd, exp_q.pop_front());
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sm_rom.md
SM_ROM -- requirements
Module: sm_rom

Interface
REQ-001 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter NODE_ID, default 0: selects the initial image file "sm_rom_<NODE_ID>.hex" (decimal NODE_ID).
REQ-003 Parameter SIZE, default 64: number of 32-bit words stored.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 a  input  32  word address (byte address >> 2).
REQ-007 rd  output  32  read data for a.
REQ-008 ld_valid  input  1  load-port write strobe.
REQ-009 ld_data  input  32  load-port write data.
REQ-010 ld_ptr  output  $clog2(SIZE+1)  next word index the load port writes.
REQ-011 ld_full  output  1  high when ld_ptr == SIZE.

Function
REQ-012 rd SHALL be combinational, zero-latency: rd = mem[a] when a < SIZE, else 32'h0.
REQ-013 The range check SHALL use all 32 bits of a; no wrap-around or aliasing (a = SIZE+3 returns 0, not mem[3]).
REQ-014 At elaboration mem SHALL be initialised from the NODE_ID image file via hex read; words not covered by the file SHALL be 0.
REQ-015 On a rising edge with ld_valid=1 and ld_full=0: mem[ld_ptr] <= ld_data; ld_ptr <= ld_ptr+1.
REQ-016 ld_valid while ld_full=1 SHALL be ignored: no write, ld_ptr held at SIZE, no wrap to 0.
REQ-017 ld_valid=0 SHALL leave mem and ld_ptr unchanged.
REQ-018 Read and load at the same address in the same cycle: rd shows the old word before the edge and the new word immediately after it.
REQ-019 Words not yet overwritten by the load port SHALL keep their image contents.

Reset
REQ-020 rst_n=0 SHALL asynchronously force ld_ptr=0 and ld_full=0, independent of clk.
REQ-021 Reset SHALL NOT alter mem contents; rd SHALL remain valid during and after reset.
REQ-022 Reset mid-load SHALL return ld_ptr to 0; words already written SHALL be retained.
REQ-023 ld_valid SHALL be ignored while rst_n=0; loading resumes on the first rising edge after release.

Configuration
REQ-024 Macro SM_ROM_LOAD_EN defined: the load port is functional per REQ-015..REQ-019.
REQ-025 SM_ROM_LOAD_EN undefined: ld_valid and ld_data are ignored, ld_ptr=0, ld_full=0 constantly, mem is read-only image contents; the port list is unchanged.

Structure
REQ-026 Shared package sm_pkg SHALL hold SM_WORD_W=32, SM_ROM_SIZE_DEF=64 and the image-file prefix string "sm_rom_".
REQ-027 One sub-module, sm_register, SHALL implement the load pointer.
REQ-028 sm_register ports, in positional order: clk, rst_n, d, q.
REQ-029 sm_register parameter WIDTH, default 32.
REQ-030 sm_register behaviour: q=0 asynchronously while rst_n=0; otherwise q<=d on every rising edge.
REQ-031 sm_register SHALL be reusable unchanged as the CPU program-counter register.

Verification
REQ-032 Image file word 0 = 32'h00500093, a=0 -> rd=32'h00500093 in the same cycle; a=SIZE (64) -> rd=0; a=32'h40000000 -> rd=0.
REQ-033 (LOAD_EN) After reset, three edges with ld_valid=1 and data 11,22,33 -> mem[0..2]=11,22,33 and ld_ptr=3; a=1 -> rd=22.
REQ-034 (LOAD_EN) 64 writes -> ld_full=1 and ld_ptr=64; a 65th write with data 32'hDEADBEEF -> no change, mem[0] still the first loaded word.
REQ-035 rst_n pulsed low between clock edges at ld_ptr=5 -> ld_ptr=0 immediately; a=4 -> rd still shows the loaded word.
REQ-036 sm_register: d=32'h10 with rst_n=0 -> q=0; rst_n=1 then one edge -> q=32'h10; rst_n dropped mid-cycle -> q=0 without waiting for an edge.
REQ-037 (without SM_ROM_LOAD_EN) ld_valid=1 for 10 cycles with data 32'hFFFFFFFF -> mem unchanged, ld_ptr=0, ld_full=0.
